// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: skid-buffer state
// encoding, default bundle widths and field offsets used when packing bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

  localparam int unsigned PIPE_CTRL_W = 4;

  // ID/EX: RD1 | RD2 | Rt | Rd | SignImm | PCPlus4, packed LSB first
  localparam int unsigned IDEX_RD1_LSB      = 0;
  localparam int unsigned IDEX_RD2_LSB      = 32;
  localparam int unsigned IDEX_RT_LSB       = 64;
  localparam int unsigned IDEX_RD_LSB       = 69;
  localparam int unsigned IDEX_SIGN_IMM_LSB = 74;
  localparam int unsigned IDEX_PC_PLUS4_LSB = 106;
  localparam int unsigned IDEX_DATA_W       = 138;

  // EX/MEM: ExecuteOut | WriteData | WriteReg | PCPlus4
  localparam int unsigned EXMEM_EXEC_OUT_LSB   = 0;
  localparam int unsigned EXMEM_WRITE_DATA_LSB = 32;
  localparam int unsigned EXMEM_WRITE_REG_LSB  = 64;
  localparam int unsigned EXMEM_PC_PLUS4_LSB   = 69;
  localparam int unsigned EXMEM_DATA_W         = 101;

  // MEM/WB: ReadData | ExecuteOut | WriteReg | PCPlus4
  localparam int unsigned MEMWB_READ_DATA_LSB = 0;
  localparam int unsigned MEMWB_EXEC_OUT_LSB  = 32;
  localparam int unsigned MEMWB_WRITE_REG_LSB = 64;
  localparam int unsigned MEMWB_PC_PLUS4_LSB  = 69;
  localparam int unsigned MEMWB_DATA_W        = 101;

  function automatic int unsigned field_msb(input int unsigned lsb, input int unsigned width);
    return lsb + width - 1;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One bundle register (control + data) with load and independent clears for
// the control and data fields. Clears take priority over load.
module pipe_stage_entry #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 101
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic              clr_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // NOTE: the entries are reset, not left undefined, because the stage must
  // present all-zero outputs while Rst_n is low. Non-blocking assignments keep
  // every register sampling its pre-edge inputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        q_ctrl <= '0;
    else if (clr_ctrl) q_ctrl <= '0;
    else if (load)     q_ctrl <= d_ctrl;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        q_data <= '0;
    else if (clr_data) q_data <= '0;
    else if (load)     q_data <= d_data;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry
// skid buffer; optional stall counter enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W           = PIPE_CTRL_W,
  parameter int unsigned DATA_W           = EXMEM_DATA_W,
  parameter bit          ZERO_DATA_ON_CLR = 1'b1
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W            = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q;
  logic              accept, send;
  logic              main_load, skid_load, main_from_skid;
  logic              clr_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign send      = out_valid && out_ready;
  assign clr_data  = Clr && ZERO_DATA_ON_CLR;

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (Clr) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && send) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (send) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (send) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (main_load),
    .clr_ctrl (Clr),
    .clr_data (clr_data),
    .d_ctrl   (main_d_ctrl),
    .d_data   (main_d_data),
    .q_ctrl   (main_ctrl),
    .q_data   (main_data)
  );

  pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (skid_load),
    .clr_ctrl (Clr),
    .clr_data (clr_data),
    .d_ctrl   (in_ctrl),
    .d_data   (in_data),
    .q_ctrl   (skid_ctrl),
    .q_data   (skid_data)
  );

  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

`ifdef PIPE_STAGE_PERF_EN
  // Saturating count of cycles a valid bundle waited on the downstream stage.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      perf_stall_cnt <= '0;
    else if (out_valid && !out_ready && (perf_stall_cnt != '1))
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid (DATA_W=8): directed scenarios plus a
// randomized run against a 2-deep FIFO reference model.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] data;
  } bundle_t;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_ctrl = '0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_ctrl;
  logic [7:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bundle_t model_q[$];

  pipe_stage_skid #(
    .CTRL_W(4),
    .DATA_W(8),
    .ZERO_DATA_ON_CLR(1'b1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Clr       (Clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  // One clock: the reference model sees the same handshake the DUT sees, then
  // the bench returns on the falling edge where outputs are sampled.
  task automatic tick();
    bit acc, snd;
    acc = in_valid && (model_q.size() < 2);
    snd = (model_q.size() > 0) && out_ready;
    @(posedge Clk);
    if (Clr) begin
      model_q.delete();
    end else begin
      if (snd) void'(model_q.pop_front());
      if (acc) model_q.push_back('{ctrl: in_ctrl, data: in_data});
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Clr       = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idle_inputs();
    @(posedge Clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_q.delete();
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    in_ctrl   = 4'hA;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 4'hA || out_data !== 8'(i))
        begin errors++; $display("FAIL pass_through_%0d: got v=%b c=%h d=%h expected v=1 c=a d=%h", i, out_valid, out_ctrl, out_data, i); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_through_ready_%0d: got %b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'h0)
      begin errors++; $display("FAIL pass_through_drain: got v=%b c=%h expected v=0 c=0", out_valid, out_ctrl); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] seen[$];
    out_ready = 1'b0;
    in_ctrl   = 4'h3;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd7 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_one: got v=%b d=%0d r=%b expected v=1 d=7 r=1", out_valid, out_data, in_ready); end
    in_data = 8'd8;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'd7)
      begin errors++; $display("FAIL bp_full: got r=%b d=%0d expected r=0 d=7", in_ready, out_data); end
    in_data = 8'd9;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd7 || out_ctrl !== 4'h3)
      begin errors++; $display("FAIL bp_hold: got r=%b v=%b c=%h d=%0d expected r=0 v=1 c=3 d=7", in_ready, out_valid, out_ctrl, out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 6 && seen.size() < 4; i++) begin
      if (out_valid) seen.push_back(out_data);
      tick();
      if (in_valid && in_ready == 1'b0) ; else if (i >= 1) in_valid = 1'b0;
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'd7 || seen[1] !== 8'd8 || seen[2] !== 8'd9)
      begin errors++; $display("FAIL bp_order: got n=%0d %p expected 7 8 9", seen.size(), seen); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_ctrl   = 4'hF;
    in_valid  = 1'b1;
    in_data   = 8'h11; tick();
    in_data   = 8'h22; tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_full: got %b expected 0", in_ready); end
    Clr = 1'b1; out_ready = 1'b1; in_data = 8'h33;
    tick();
    Clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || in_ready !== 1'b1 || out_data !== 8'h00)
      begin errors++; $display("FAIL flush_full: got v=%b c=%h r=%b d=%h expected v=0 c=0 r=1 d=00", out_valid, out_ctrl, in_ready, out_data); end
    // Flush while ONE with an acceptable offer: the offer is dropped.
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b0;
    tick();
    Clr = 1'b1; in_data = 8'h55;
    tick();
    Clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00)
      begin errors++; $display("FAIL flush_one: got v=%b r=%b d=%h expected v=0 r=1 d=00", out_valid, in_ready, out_data); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_ctrl   = 4'h6;
    in_valid  = 1'b1;
    in_data   = 8'hA1; tick();
    in_data   = 8'hA2; tick();
    in_valid  = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || out_data !== 8'h00 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async_reset: got v=%b c=%h d=%h r=%b expected v=0 c=0 d=00 r=1", out_valid, out_ctrl, out_data, in_ready); end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ctrl !== 4'h6)
      begin errors++; $display("FAIL reset_first_push: got v=%b c=%h d=%h expected v=1 c=6 d=5a", out_valid, out_ctrl, out_data); end
    tick();
  endtask

  task automatic test_random();
    int sent = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2))
        begin errors++; $display("FAIL random_flags cyc %0d: got v=%b r=%b expected v=%b r=%b", cyc, out_valid, in_ready, model_q.size() > 0, model_q.size() < 2); end
      if (model_q.size() > 0) begin
        checks++;
        if (out_ctrl !== model_q[0].ctrl || out_data !== model_q[0].data)
          begin errors++; $display("FAIL random_data cyc %0d: got c=%h d=%h expected c=%h d=%h", cyc, out_ctrl, out_data, model_q[0].ctrl, model_q[0].data); end
        if (out_ready) sent++;
      end else begin
        checks++;
        if (out_ctrl !== 4'h0) begin errors++; $display("FAIL random_ctrl_mask cyc %0d: got %h expected 0", cyc, out_ctrl); end
      end
      in_valid  = $urandom_range(1, 0) == 1;
      out_ready = $urandom_range(1, 0) == 1;
      Clr       = $urandom_range(63, 0) == 0;
      in_ctrl   = 4'($urandom);
      in_data   = 8'($urandom);
      tick();
    end
    idle_inputs();
    checks++;
    if (sent < 1000) begin errors++; $display("FAIL random_throughput: got %0d sends expected at least 1000", sent); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (perf_stall_cnt !== 4'd0) begin errors++; $display("FAIL perf_reset: got %0d expected 0", perf_stall_cnt); end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_q.delete();
    in_valid = 1'b1; in_ctrl = 4'h1; in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_saturate: got %0d expected 15", perf_stall_cnt); end
    Clr = 1'b1; tick(); Clr = 1'b0; tick();
    checks++;
    if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_clr_hold: got %0d expected 15", perf_stall_cnt); end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (perf_stall_cnt !== 4'd0) begin errors++; $display("FAIL perf_rst_clear: got %0d expected 0", perf_stall_cnt); end
    @(negedge Clk);
    Rst_n = 1'b1;
    model_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the MIPS datapath.
- Successor to the fixed-field stage registers: one generic block carries an arbitrary control/data bundle between stages.
- Replaces the single enable with a valid/ready handshake backed by a 2-entry skid buffer, so back-pressure never combinationally crosses a stage boundary.
- Separate synchronous flush for hazard squashing; control bits are always zeroed on flush, data bits optionally.

Parameters:
- CTRL_W, 4, width of the control field (RegWrite/MemtoReg/MemWrite/jump style bits); zeroed on flush.
- DATA_W, 101, width of the datapath field (e.g. ExecuteOut 32 + WriteData 32 + WriteReg 5 + PCPlus4 32).
- ZERO_DATA_ON_CLR, 1, 1 = data field also zeroed on flush; 0 = data field holds its value.
- CNT_W, 16, width of the stall counter (optional feature only).

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Clr  in  1  synchronous flush, highest priority after reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept; driven from a register.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream datapath bits.
- out_valid  out  1  downstream bundle valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bits to next stage; 0 whenever out_valid=0.
- out_data  out  DATA_W  datapath bits to next stage.
- perf_stall_cnt  out  CNT_W  present only with the macro.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
- Handshakes: accept = in_valid & in_ready; send = out_valid & out_ready.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is a registered copy of (next state != FULL).
- out_valid = 1 in ONE and FULL. out_ctrl is masked to 0 when out_valid=0.
- EMPTY:
  - accept -> ONE, main <= in.
- ONE:
  - accept & send -> ONE, main <= in.
  - accept & !send -> FULL, skid <= in.
  - !accept & send -> EMPTY.
  - otherwise hold.
- FULL:
  - send -> ONE, main <= skid.
  - no accept is possible in FULL.
- Ordering and timing:
  - Strict FIFO ordering.
  - Latency 1 cycle from accept to out_valid when EMPTY.
  - Sustained throughput 1 bundle/cycle while out_ready=1.
- Clr:
  - Next edge -> EMPTY, in_ready=1.
  - Main and skid ctrl <= 0. Data <= 0 if ZERO_DATA_ON_CLR, else held.
  - A bundle offered in the same cycle as Clr is dropped; in_ready is not lowered for it.
  - Clr overrides simultaneous send and accept.
- Rst_n low, asynchronous and at any point including mid-transfer:
  - State EMPTY, in_ready=1, out_valid=0.
  - out_ctrl=0, out_data=0, skid contents=0, perf_stall_cnt=0.
  - Deassertion takes effect at the next rising edge.
- Holding: out_data/out_ctrl are stable while out_valid & !out_ready (no change until send).
- Input-side assumptions: no combinational path from out_ready to in_ready or any output. in_* may change freely when in_ready=0.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; cleared by Rst_n only, not by Clr.
- Undefined:
  - Port and counter logic are absent.
  - Block behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - State encoding enum (ST_EMPTY=2'b00, ST_ONE=2'b01, ST_FULL=2'b11).
  - Default widths for the ID/EX, EX/MEM and MEM/WB bundles.
  - Localparam field offsets used to pack/unpack the bundles at instantiation sites.
- One natural sub-module: pipe_stage_entry, a CTRL_W+DATA_W register with load, clear-ctrl and clear-data inputs. It is instantiated twice (main, skid).

Test Plan:
- Pass-through: out_ready=1; push ctrl=4'hA/data=1, 2, 3 on consecutive cycles -> out_valid at cycles +1..+3 carrying 1, 2, 3; in_ready stays 1.
- Back-pressure: out_ready=0; push data 7, 8, 9 -> 7 accepted (ONE), 8 accepted (FULL), in_ready=0 the cycle after 8, 9 held upstream. Raise out_ready -> outputs 7, 8, 9 in order, no loss or duplicate.
- Flush: FULL holding ctrl=4'hF; assert Clr together with out_ready=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, the offered bundle dropped. Data is 0 with ZERO_DATA_ON_CLR=1 and held with 0.
- Async reset mid-stall: FULL, drop Rst_n between clock edges -> outputs 0 immediately. Release -> EMPTY, in_ready=1, first push appears 1 cycle later.
- Random valid/ready at 50% on each side for 10k cycles with DATA_W=8 -> scoreboard order match; no combinational out_ready->in_ready path (formal or lint check).
- PIPE_STAGE_PERF_EN with CNT_W=4: out_valid high, out_ready low for 20 cycles -> perf_stall_cnt=15 and holds. A Clr pulse leaves it at 15; Rst_n clears it to 0.
